// File: rtl/alu_op_decoder.sv
// Decode stage for the barrel RISC-V core: RV32I + LOTOUPC instruction to ALU
// control, operand selects and immediate, registered with stall/flush control.

package riscv_pkg;
  localparam logic [3:0] ADD_OP     = 4'h0;
  localparam logic [3:0] SUB_OP     = 4'h1;
  localparam logic [3:0] SLL_OP     = 4'h2;
  localparam logic [3:0] XOR_OP     = 4'h3;
  localparam logic [3:0] SRL_OP     = 4'h4;
  localparam logic [3:0] SRA_OP     = 4'h5;
  localparam logic [3:0] OR_OP      = 4'h6;
  localparam logic [3:0] AND_OP     = 4'h7;
  localparam logic [3:0] PASS_OP    = 4'h8;
  localparam logic [3:0] LOTOUPC_OP = 4'h9;
endpackage

module alu_op_decoder
  import riscv_pkg::*;
#(
  parameter int ALUOP_WIDTH = 4,
  parameter int DWIDTH      = 32,
  parameter int TID_WIDTH   = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_valid,
  input  logic [DWIDTH-1:0]      i_instr,
  input  logic [DWIDTH-1:0]      i_pc,
  input  logic [TID_WIDTH-1:0]   i_tid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [ALUOP_WIDTH-1:0] o_aluop,
  output logic                   o_op1_sel,
  output logic [1:0]             o_op2_sel,
  output logic [DWIDTH-1:0]      o_imm,
  output logic [4:0]             o_rs1,
  output logic [4:0]             o_rs2,
  output logic [4:0]             o_rd,
  output logic [1:0]             o_setlt,
  output logic                   o_illegal,
  output logic [DWIDTH-1:0]      o_pc,
  output logic [TID_WIDTH-1:0]   o_tid,
  output logic [CNT_WIDTH-1:0]   o_illegal_cnt
);

  typedef enum logic [6:0] {
    OPC_OP_IMM  = 7'b0010011,
    OPC_OP      = 7'b0110011,
    OPC_LUI     = 7'b0110111,
    OPC_AUIPC   = 7'b0010111,
    OPC_LOAD    = 7'b0000011,
    OPC_STORE   = 7'b0100011,
    OPC_JAL     = 7'b1101111,
    OPC_JALR    = 7'b1100111,
    OPC_BRANCH  = 7'b1100011,
    OPC_CUSTOM0 = 7'b0001011
  } opcode_e;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [DWIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f3    = i_instr[14:12];
  assign f7    = i_instr[31:25];
  assign imm_i = DWIDTH'($signed(i_instr[31:20]));
  assign imm_s = DWIDTH'($signed({i_instr[31:25], i_instr[11:7]}));
  assign imm_b = DWIDTH'($signed({i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}));
  assign imm_u = DWIDTH'($signed({i_instr[31:12], 12'b0}));
  assign imm_j = DWIDTH'($signed({i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}));

  // Shared f3 mapping for OP-IMM and the f7=0 half of OP.
  logic [3:0] arith_op;
  logic [1:0] arith_lt;
  logic       arith_ok;

  always_comb begin
    arith_op = ADD_OP;
    arith_lt = 2'b00;
    arith_ok = 1'b1;
    case (f3)
      3'b000: arith_op = ADD_OP;
      3'b001: begin
        arith_op = SLL_OP;
        arith_ok = (f7 == F7_ZERO);
      end
      3'b010: begin
        arith_op = SUB_OP;
        arith_lt = 2'b01;
      end
      3'b011: begin
        arith_op = SUB_OP;
        arith_lt = 2'b10;
      end
      3'b100: arith_op = XOR_OP;
      3'b101: begin
        arith_op = (f7 == F7_ALT) ? SRA_OP : SRL_OP;
        arith_ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
      end
      3'b110: arith_op = OR_OP;
      default: arith_op = AND_OP;
    endcase
  end

  logic [3:0]        dec_op;
  logic              dec_op1;
  logic [1:0]        dec_op2;
  logic [DWIDTH-1:0] dec_imm;
  logic [1:0]        dec_lt;
  logic              dec_ok;

  always_comb begin
    dec_op  = ADD_OP;
    dec_op1 = 1'b0;
    dec_op2 = 2'b00;
    dec_imm = '0;
    dec_lt  = 2'b00;
    dec_ok  = 1'b0;
    case (opcode_e'(i_instr[6:0]))
      OPC_OP_IMM: begin
        dec_op  = arith_op;
        dec_lt  = arith_lt;
        dec_op2 = 2'b01;
        dec_imm = imm_i;
        dec_ok  = arith_ok;
      end
      OPC_OP: begin
        if (f7 == F7_ZERO) begin
          dec_op = arith_op;
          dec_lt = arith_lt;
          dec_ok = 1'b1;
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec_op = SUB_OP;
          dec_ok = 1'b1;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec_op = SRA_OP;
          dec_ok = 1'b1;
        end
      end
      OPC_LUI: begin
        dec_op  = PASS_OP;
        dec_op2 = 2'b01;
        dec_imm = imm_u;
        dec_ok  = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op1 = 1'b1;
        dec_op2 = 2'b01;
        dec_imm = imm_u;
        dec_ok  = 1'b1;
      end
      OPC_LOAD: begin
        dec_op2 = 2'b01;
        dec_imm = imm_i;
        dec_ok  = 1'b1;
      end
      OPC_STORE: begin
        dec_op2 = 2'b01;
        dec_imm = imm_s;
        dec_ok  = 1'b1;
      end
      OPC_JAL: begin
        dec_op1 = 1'b1;
        dec_op2 = 2'b10;
        dec_imm = imm_j;
        dec_ok  = 1'b1;
      end
      OPC_JALR: begin
        dec_op1 = 1'b1;
        dec_op2 = 2'b10;
        dec_imm = imm_i;
        dec_ok  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_op  = SUB_OP;
        dec_imm = imm_b;
        dec_ok  = 1'b1;
      end
      OPC_CUSTOM0: begin
        if (f3 == 3'b000 && f7 == F7_ZERO) begin
          dec_op = LOTOUPC_OP;
          dec_ok = 1'b1;
        end
      end
      default: dec_ok = 1'b0;
    endcase
    // Illegal encodings present a neutral ADD with no immediate.
    if (!dec_ok) begin
      dec_op  = ADD_OP;
      dec_op1 = 1'b0;
      dec_op2 = 2'b00;
      dec_imm = '0;
      dec_lt  = 2'b00;
    end
  end

  logic                   valid_q, valid_d;
  logic [ALUOP_WIDTH-1:0] aluop_q, aluop_d;
  logic                   op1_sel_q, op1_sel_d;
  logic [1:0]             op2_sel_q, op2_sel_d;
  logic [DWIDTH-1:0]      imm_q, imm_d;
  logic [4:0]             rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [1:0]             setlt_q, setlt_d;
  logic                   illegal_q, illegal_d;
  logic [DWIDTH-1:0]      pc_q, pc_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

  always_comb begin
    valid_d   = valid_q;
    aluop_d   = aluop_q;
    op1_sel_d = op1_sel_q;
    op2_sel_d = op2_sel_q;
    imm_d     = imm_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    setlt_d   = setlt_q;
    illegal_d = illegal_q;
    pc_d      = pc_q;
    tid_d     = tid_q;
    cnt_d     = cnt_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (!i_stall) begin
      valid_d   = i_valid;
      aluop_d   = ALUOP_WIDTH'(dec_op);
      op1_sel_d = dec_op1;
      op2_sel_d = dec_op2;
      imm_d     = dec_imm;
      rs1_d     = i_instr[19:15];
      rs2_d     = i_instr[24:20];
      rd_d      = i_instr[11:7];
      setlt_d   = dec_lt;
      illegal_d = i_valid && !dec_ok;
      pc_d      = i_pc;
      tid_d     = i_tid;
      if (i_valid && !dec_ok && cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      aluop_q   <= ALUOP_WIDTH'(ADD_OP);
      op1_sel_q <= 1'b0;
      op2_sel_q <= '0;
      imm_q     <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      setlt_q   <= '0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      tid_q     <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      aluop_q   <= aluop_d;
      op1_sel_q <= op1_sel_d;
      op2_sel_q <= op2_sel_d;
      imm_q     <= imm_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      setlt_q   <= setlt_d;
      illegal_q <= illegal_d;
      pc_q      <= pc_d;
      tid_q     <= tid_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_aluop       = aluop_q;
  assign o_op1_sel     = op1_sel_q;
  assign o_op2_sel     = op2_sel_q;
  assign o_imm         = imm_q;
  assign o_rs1         = rs1_q;
  assign o_rs2         = rs2_q;
  assign o_rd          = rd_q;
  assign o_setlt       = setlt_q;
  assign o_illegal     = illegal_q;
  assign o_pc          = pc_q;
  assign o_tid         = tid_q;
  assign o_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: randomized instruction stream against a behavioural
// model, plus a narrow-counter instance to reach counter saturation quickly.

module tb_alu_op_decoder;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_stall, i_flush;
  logic [31:0] i_instr, i_pc;
  logic [3:0]  i_tid;

  logic        o_valid, o_op1_sel, o_illegal;
  logic [3:0]  o_aluop, o_tid;
  logic [1:0]  o_op2_sel, o_setlt;
  logic [31:0] o_imm, o_pc;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [15:0] o_illegal_cnt;

  logic        s_valid, s_op1_sel, s_illegal;
  logic [3:0]  s_aluop, s_tid;
  logic [1:0]  s_op2_sel, s_setlt;
  logic [31:0] s_imm, s_pc;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [2:0]  s_illegal_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  alu_op_decoder dut (
    .clk(clk), .reset(rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
    .i_tid(i_tid), .i_stall(i_stall), .i_flush(i_flush), .o_valid(o_valid),
    .o_aluop(o_aluop), .o_op1_sel(o_op1_sel), .o_op2_sel(o_op2_sel), .o_imm(o_imm),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_setlt(o_setlt),
    .o_illegal(o_illegal), .o_pc(o_pc), .o_tid(o_tid), .o_illegal_cnt(o_illegal_cnt)
  );

  alu_op_decoder #(.CNT_WIDTH(3)) dut_small (
    .clk(clk), .reset(rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
    .i_tid(i_tid), .i_stall(i_stall), .i_flush(i_flush), .o_valid(s_valid),
    .o_aluop(s_aluop), .o_op1_sel(s_op1_sel), .o_op2_sel(s_op2_sel), .o_imm(s_imm),
    .o_rs1(s_rs1), .o_rs2(s_rs2), .o_rd(s_rd), .o_setlt(s_setlt),
    .o_illegal(s_illegal), .o_pc(s_pc), .o_tid(s_tid), .o_illegal_cnt(s_illegal_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluop;
    logic        op1;
    logic [1:0]  op2;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  setlt;
    logic        illegal;
    logic [31:0] pc;
    logic [3:0]  tid;
  } out_t;

  function automatic out_t model_decode(input logic [31:0] w);
    out_t        d;
    logic [3:0]  tbl [0:7];
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] sx, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic        legal;
    tbl = '{ADD_OP, SLL_OP, SUB_OP, SUB_OP, XOR_OP, SRL_OP, OR_OP, AND_OP};
    d = '0;
    opc = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    sx = {32{w[31]}};
    imm_i = (sx << 12) | 32'(w[31:20]);
    imm_s = (sx << 12) | (32'(w[31:25]) << 5) | 32'(w[11:7]);
    imm_b = (sx << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
    imm_u = {w[31:12], 12'h000};
    imm_j = (sx << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    legal = 1'b0;
    if (opc == 7'h13 || (opc == 7'h33 && f7 == 7'h00)) begin
      if (f3 == 3'd1) legal = (f7 == 7'h00);
      else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20);
      else legal = 1'b1;
      d.aluop = (f3 == 3'd5 && f7 == 7'h20) ? SRA_OP : tbl[f3];
      d.setlt = (f3 == 3'd2) ? 2'b01 : (f3 == 3'd3) ? 2'b10 : 2'b00;
      if (opc == 7'h13) begin
        d.op2 = 2'b01;
        d.imm = imm_i;
      end
    end else if (opc == 7'h33 && f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
      legal = 1'b1;
      d.aluop = (f3 == 3'd0) ? SUB_OP : SRA_OP;
    end else begin
      legal = 1'b1;
      case (opc)
        7'h37: begin d.aluop = PASS_OP; d.op2 = 2'b01; d.imm = imm_u; end
        7'h17: begin d.aluop = ADD_OP; d.op1 = 1'b1; d.op2 = 2'b01; d.imm = imm_u; end
        7'h03: begin d.aluop = ADD_OP; d.op2 = 2'b01; d.imm = imm_i; end
        7'h23: begin d.aluop = ADD_OP; d.op2 = 2'b01; d.imm = imm_s; end
        7'h6F: begin d.aluop = ADD_OP; d.op1 = 1'b1; d.op2 = 2'b10; d.imm = imm_j; end
        7'h67: begin d.aluop = ADD_OP; d.op1 = 1'b1; d.op2 = 2'b10; d.imm = imm_i; end
        7'h63: begin d.aluop = SUB_OP; d.imm = imm_b; end
        7'h0B: begin d.aluop = LOTOUPC_OP; legal = (f3 == 3'd0 && f7 == 7'h00); end
        default: legal = 1'b0;
      endcase
    end
    if (!legal) d = '0;
    d.illegal = !legal;
    d.rs1 = w[19:15];
    d.rs2 = w[24:20];
    d.rd  = w[11:7];
    return d;
  endfunction

  out_t        m;
  logic [15:0] m_cnt;
  logic [2:0]  m_cnt_small;
  bit          model_ready = 1'b0;

  always @(posedge clk) begin
    out_t d;
    if (rst) begin
      m = '0;
      m_cnt = 16'd0;
      m_cnt_small = 3'd0;
      model_ready = 1'b1;
    end else if (i_flush) begin
      m.valid = 1'b0;
    end else if (!i_stall) begin
      d = model_decode(i_instr);
      if (i_valid && d.illegal) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (m_cnt_small != 3'd7) m_cnt_small = m_cnt_small + 3'd1;
      end
      d.illegal = d.illegal & i_valid;
      d.valid = i_valid;
      d.pc = i_pc;
      d.tid = i_tid;
      m = d;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      check("valid", 32'(o_valid), 32'(m.valid));
      check("aluop", 32'(o_aluop), 32'(m.aluop));
      check("op1_sel", 32'(o_op1_sel), 32'(m.op1));
      check("op2_sel", 32'(o_op2_sel), 32'(m.op2));
      check("imm", o_imm, m.imm);
      check("rs1", 32'(o_rs1), 32'(m.rs1));
      check("rs2", 32'(o_rs2), 32'(m.rs2));
      check("rd", 32'(o_rd), 32'(m.rd));
      check("setlt", 32'(o_setlt), 32'(m.setlt));
      check("illegal", 32'(o_illegal), 32'(m.illegal));
      check("pc", o_pc, m.pc);
      check("tid", 32'(o_tid), 32'(m.tid));
      check("illegal_cnt", 32'(o_illegal_cnt), 32'(m_cnt));
      check("illegal_cnt_small", 32'(s_illegal_cnt), 32'(m_cnt_small));
    end
  end

  task automatic step(input logic r, input logic v, input logic st, input logic fl,
                      input logic [31:0] ins);
    rst = r;
    i_valid = v;
    i_stall = st;
    i_flush = fl;
    i_instr = ins;
    i_pc = $urandom;
    i_tid = 4'($urandom);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [0:10];
    logic [31:0] w;
    int unsigned sel;
    opcs = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63, 7'h0B, 7'h13};
    w = $urandom;
    sel = $urandom_range(0, 11);
    if (sel <= 10) w[6:0] = opcs[sel];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    if (w[6:0] == 7'h0B && $urandom_range(0, 1) == 0) w[14:12] = 3'd0;
    return w;
  endfunction

  initial begin
    logic [31:0] exp_imm;
    rst = 1'b1;
    i_valid = 1'b1;
    i_stall = 1'b0;
    i_flush = 1'b0;
    i_instr = 32'h0;
    i_pc = 32'h0;
    i_tid = 4'h0;

    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_cnt", 32'(o_illegal_cnt), 32'd0);
    check("reset_aluop", 32'(o_aluop), 32'(ADD_OP));

    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h40A3_5333);
    check("sra_valid", 32'(o_valid), 32'd1);
    check("sra_aluop", 32'(o_aluop), 32'(SRA_OP));
    check("sra_op2", 32'(o_op2_sel), 32'd0);
    check("sra_rd", 32'(o_rd), 32'd6);
    check("sra_rs1", 32'(o_rs1), 32'd6);
    check("sra_rs2", 32'(o_rs2), 32'd10);
    check("sra_illegal", 32'(o_illegal), 32'd0);

    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFF0_0093);
    check("addi_aluop", 32'(o_aluop), 32'(ADD_OP));
    check("addi_op2", 32'(o_op2_sel), 32'd1);
    check("addi_imm", o_imm, 32'hFFFF_FFFF);

    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5297);
    check("auipc_aluop", 32'(o_aluop), 32'(ADD_OP));
    check("auipc_op1", 32'(o_op1_sel), 32'd1);
    check("auipc_imm", o_imm, 32'h1234_5000);
    check("auipc_rd", 32'(o_rd), 32'd5);

    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_058B);
    check("lotoupc_aluop", 32'(o_aluop), 32'(LOTOUPC_OP));
    check("lotoupc_rd", 32'(o_rd), 32'd11);

    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_158B);
    check("custom_bad_illegal", 32'(o_illegal), 32'd1);
    check("custom_bad_cnt", 32'(o_illegal_cnt), 32'd1);

    // Invalid illegal instruction: no flag, no count.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_158B);
    check("inv_illegal", 32'(o_illegal), 32'd0);
    check("inv_cnt", 32'(o_illegal_cnt), 32'd1);

    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFF0_0093);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000);
      check("stall_valid", 32'(o_valid), 32'd1);
      check("stall_imm", o_imm, 32'hFFFF_FFFF);
      check("stall_op2", 32'(o_op2_sel), 32'd1);
      check("stall_cnt", 32'(o_illegal_cnt), 32'd1);
    end
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000);
    check("flush_valid", 32'(o_valid), 32'd0);
    check("flush_imm", o_imm, 32'hFFFF_FFFF);
    check("flush_cnt", 32'(o_illegal_cnt), 32'd1);

    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0), rand_instr());
    end

    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000);
      check("sat_small_cnt", 32'(s_illegal_cnt), (k < 7) ? 32'(k) : 32'd7);
      check("sat_big_cnt", 32'(o_illegal_cnt), 32'(k));
    end

    exp_imm = 32'h0000_0000;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0013);
    check("sat_hold_imm", o_imm, exp_imm);
    check("sat_hold_small", 32'(s_illegal_cnt), 32'd7);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
